dct_basis_accum: RTL and testbench

- Sequential successor to the per-(k1,k2) 2D cosine LUTs: computes one 8x8 2D DCT coefficient X(k1,k2) for any runtime-selected k1,k2 from a streamed 64-pixel block.
- Basis terms are formed on the fly from a shared 1D cosine ROM, multiplied by pixels and accumulated.
- Sits between the block buffer and the coefficient store of the DCT path.

---
 rtl/dct_pkg.sv | 67 ++++++
 rtl/dct_cos_rom.sv | 19 +
 rtl/dct_basis_accum.sv | 176 +++++++++++++++++
 tb/tb_dct_basis_accum.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and the 1D cosine table builder for the
// 8x8 DCT basis accumulator.
package dct_pkg;

   localparam int N     = 8;
   localparam int LOG2N = 3;
   localparam int NPIX  = 64;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   // Entry index is {k, n}; each entry holds a signed value in the low bits.
   typedef logic [NPIX-1:0][31:0] cos_tab_t;

   // cos(m*pi/16) for m = 0..8 in Q30, used to build the rounded table.
   function automatic longint cos_q30(input int unsigned m);
      case (m)
         0:       cos_q30 = 64'd1073741824;
         1:       cos_q30 = 64'd1053110176;
         2:       cos_q30 = 64'd992008094;
         3:       cos_q30 = 64'd892783698;
         4:       cos_q30 = 64'd759250125;
         5:       cos_q30 = 64'd596538995;
         6:       cos_q30 = 64'd410903207;
         7:       cos_q30 = 64'd209476638;
         default: cos_q30 = 64'd0;
      endcase
   endfunction

   // C(k,n) = round(cos((2n+1)k*pi/16) * 2^frac), half away from zero.
   // The angle is folded into the first quadrant so only nine magnitudes
   // are needed; rounding is applied to the magnitude, then the sign.
   function automatic cos_tab_t cos_table(input int unsigned frac);
      cos_tab_t    tab;
      int unsigned a;
      int unsigned m;
      logic        neg;
      longint      mag;
      longint      r;
      tab = '0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned n = 0; n < N; n++) begin
            a = ((2 * n + 1) * k) % 32;
            if (a <= 8) begin
               m   = a;
               neg = 1'b0;
            end else if (a <= 16) begin
               m   = 16 - a;
               neg = 1'b1;
            end else if (a <= 24) begin
               m   = a - 16;
               neg = 1'b1;
            end else begin
               m   = 32 - a;
               neg = 1'b0;
            end
            mag = cos_q30(m);
            r   = (mag + (64'sd1 <<< (29 - frac))) >>> (30 - frac);
            if (neg) begin
               r = -r;
            end
            tab[k * N + n] = 32'(r);
         end
      end
      return tab;
   endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// Combinational 1D cosine lookup: (k, n) -> C(k,n), signed COS_FRAC+2 bits.
module dct_cos_rom
   import dct_pkg::*;
#(
   parameter int COS_FRAC = 8
) (
   input  logic [LOG2N-1:0]          k_i,
   input  logic [LOG2N-1:0]          n_i,
   output logic signed [COS_FRAC+1:0] c_o
);

   localparam cos_tab_t TAB = cos_table(COS_FRAC);

   // Table read; entries are stored sign-extended, keep the low bits.
   always_comb begin
      c_o = (COS_FRAC + 2)'(TAB[{k_i, n_i}]);
   end

endmodule

// File: rtl/dct_basis_accum.sv
// Sequential 8x8 2D DCT coefficient engine: one X(k1,k2) per streamed block.
// Basis terms are built from two 1D cosine lookups, multiplied by the pixel
// and accumulated through a two-stage pipeline.
// Build option: DCT_BASIS_ACCUM_SAT_EN saturates the coefficient to OUT_W
// bits; without it the coefficient is the low OUT_W accumulator bits.
module dct_basis_accum
   import dct_pkg::*;
#(
   parameter int DATA_W   = 9,
   parameter int COS_FRAC = 8,
   parameter int ACC_W    = 32,
   parameter int OUT_W    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [LOG2N-1:0]         cmd_k1,
   input  logic [LOG2N-1:0]         cmd_k2,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DATA_W-1:0] s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [OUT_W-1:0]  m_coef
);

   localparam int CW = COS_FRAC + 2;
   localparam int BW = COS_FRAC + 3;
   localparam int PW = DATA_W + BW;
   localparam logic signed [2*CW-1:0] ROUND = (2 * CW)'(64'sd1 <<< (COS_FRAC - 1));

`ifdef DCT_BASIS_ACCUM_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

   state_t                   state_q;
   state_t                   state_d;
   logic [LOG2N-1:0]         k1_q;
   logic [LOG2N-1:0]         k2_q;
   logic [2*LOG2N-1:0]       cnt_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     a_valid_q;
   logic signed [DATA_W-1:0] a_pix_q;
   logic signed [BW-1:0]     a_basis_q;
   logic                     b_valid_q;
   logic signed [PW-1:0]     b_prod_q;

   logic signed [CW-1:0]     c_row;
   logic signed [CW-1:0]     c_col;
   logic signed [2*CW-1:0]   c_prod;
   logic signed [BW-1:0]     basis_d;
   logic                     cmd_fire;
   logic                     pix_fire;

   // Row term indexed by n1 = cnt[5:3], column term by n2 = cnt[2:0].
   dct_cos_rom #(.COS_FRAC(COS_FRAC)) u_rom_row (
      .k_i (k1_q),
      .n_i (cnt_q[2*LOG2N-1:LOG2N]),
      .c_o (c_row)
   );

   dct_cos_rom #(.COS_FRAC(COS_FRAC)) u_rom_col (
      .k_i (k2_q),
      .n_i (cnt_q[LOG2N-1:0]),
      .c_o (c_col)
   );

   // 2D basis from the two 1D terms, rounded back to COS_FRAC fraction bits.
   always_comb begin
      c_prod  = c_row * c_col;
      basis_d = BW'((c_prod + ROUND) >>> COS_FRAC);
   end

   // Next-state logic and handshake outputs derived purely from the state.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            s_ready = 1'b1;
            if (s_valid && (cnt_q == (2 * LOG2N)'(NPIX - 1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!a_valid_q && !b_valid_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            m_valid = 1'b1;
            if (m_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      cmd_fire = cmd_valid & cmd_ready;
      pix_fire = s_valid & s_ready;
   end

   // Coefficient reduction; held at zero outside DONE so it is stable and defined.
   always_comb begin
      m_coef = '0;
      if (state_q == DONE) begin
`ifdef DCT_BASIS_ACCUM_SAT_EN
         if (acc_q > SAT_MAX) begin
            m_coef = OUT_W'(SAT_MAX);
         end else if (acc_q < SAT_MIN) begin
            m_coef = OUT_W'(SAT_MIN);
         end else begin
            m_coef = OUT_W'(acc_q);
         end
`else
         m_coef = OUT_W'(acc_q);
`endif
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command latch, pixel counter, two-stage multiply pipeline and accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         k1_q      <= '0;
         k2_q      <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         a_valid_q <= 1'b0;
         a_pix_q   <= '0;
         a_basis_q <= '0;
         b_valid_q <= 1'b0;
         b_prod_q  <= '0;
      end else begin
         a_valid_q <= pix_fire;
         if (pix_fire) begin
            a_pix_q   <= s_data;
            a_basis_q <= basis_d;
         end
         b_valid_q <= a_valid_q;
         if (a_valid_q) begin
            b_prod_q <= PW'(a_pix_q) * PW'(a_basis_q);
         end
         if (cmd_fire) begin
            acc_q <= '0;
         end else if (b_valid_q) begin
            acc_q <= acc_q + ACC_W'(b_prod_q);
         end
         if (cmd_fire) begin
            cnt_q <= '0;
            k1_q  <= cmd_k1;
            k2_q  <= cmd_k2;
         end else if (pix_fire) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dct_basis_accum.sv
// Self-checking bench for dct_basis_accum: default-size instance for the
// functional scenarios plus a narrow instance (DATA_W=8, OUT_W=16) for the
// coefficient reduction behaviour.
`timescale 1ns/1ps
module tb_dct_basis_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst = 1'b1;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [2:0]         cmd_k1 = '0;
   logic [2:0]         cmd_k2 = '0;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic signed [8:0]  s_data = '0;
   logic               m_valid;
   logic               m_ready = 1'b0;
   logic signed [31:0] m_coef;

   logic               sm_cmd_valid = 1'b0;
   logic               sm_cmd_ready;
   logic [2:0]         sm_cmd_k1 = '0;
   logic [2:0]         sm_cmd_k2 = '0;
   logic               sm_s_valid = 1'b0;
   logic               sm_s_ready;
   logic signed [7:0]  sm_s_data = '0;
   logic               sm_m_valid;
   logic               sm_m_ready = 1'b1;
   logic signed [15:0] sm_m_coef;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_last   = 0;
   int pix_buf[64];
   int ctab[8][8];
   int exp_q[$];

   logic hold_mon   = 1'b0;
   logic ready_seen = 1'b0;

   dct_basis_accum u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_k1    (cmd_k1),
      .cmd_k2    (cmd_k2),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_coef    (m_coef)
   );

   dct_basis_accum #(.DATA_W(8), .COS_FRAC(8), .ACC_W(32), .OUT_W(16)) u_small (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (sm_cmd_valid),
      .cmd_ready (sm_cmd_ready),
      .cmd_k1    (sm_cmd_k1),
      .cmd_k2    (sm_cmd_k2),
      .s_valid   (sm_s_valid),
      .s_ready   (sm_s_ready),
      .s_data    (sm_s_data),
      .m_valid   (sm_m_valid),
      .m_ready   (sm_m_ready),
      .m_coef    (sm_m_coef)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (hold_mon && cmd_ready) ready_seen = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Golden cosine table from real arithmetic, rounded half away from zero.
   task automatic init_ctab();
      real pi;
      real x;
      pi = 3.14159265358979;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 8; n++) begin
            x = $cos(real'((2 * n + 1) * k) * pi / 16.0) * 256.0;
            if (x >= 0.0) ctab[k][n] = int'($floor(x + 0.5));
            else          ctab[k][n] = -int'($floor(-x + 0.5));
         end
      end
   endtask

   function automatic int model_coef(input int k1, input int k2);
      int sum;
      int b;
      sum = 0;
      for (int i = 0; i < 64; i++) begin
         b   = (ctab[k1][i / 8] * ctab[k2][i % 8] + 128) >>> 8;
         sum = sum + pix_buf[i] * b;
      end
      return sum;
   endfunction

   task automatic send_cmd(input int k1, input int k2, output bit ok);
      int budget;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      cmd_k1    = 3'(k1);
      cmd_k2    = 3'(k2);
      budget    = 200;
      while (!cmd_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (cmd_ready) begin
         tick();
         ok = 1'b1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic send_pixels(input int first, input int last, input int gap_pct, output bit ok);
      int budget;
      ok = 1'b1;
      for (int i = first; i <= last; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            s_valid = 1'b0;
            tick();
         end
         s_valid = 1'b1;
         s_data  = 9'(pix_buf[i]);
         budget  = 200;
         while (!s_ready && budget > 0) begin
            tick();
            budget--;
         end
         if (s_ready) begin
            tick();
            t_last = cyc;
         end else begin
            ok = 1'b0;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_mvalid(output bit ok);
      int budget;
      budget = 200;
      while (!m_valid && budget > 0) begin
         tick();
         budget--;
      end
      ok = m_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
      n_checks++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
      n_checks++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
      n_checks++;
      if (m_coef !== 32'sd0) begin n_fail++; $display("FAIL reset_m_coef: got %0d expected 0", m_coef); end
      n_checks++;
      if (sm_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_small_m_valid: got %0b expected 0", sm_m_valid); end
   endtask

   task automatic test_dc();
      bit ok;
      int exp;
      for (int i = 0; i < 64; i++) pix_buf[i] = 1;
      exp_q.push_back(16384);
      m_ready = 1'b1;
      send_cmd(0, 0, ok);
      send_pixels(0, 63, 0, ok);
      wait_mvalid(ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL dc_timeout: got m_valid 0 expected 1"); end
      n_checks++;
      if (cyc - t_last !== 3) begin n_fail++; $display("FAIL dc_latency: got %0d expected 3", cyc - t_last); end
      n_checks++;
      if (m_coef !== exp) begin n_fail++; $display("FAIL dc_coef: got %0d expected %0d", m_coef, exp); end
      tick();
      n_checks++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL dc_m_valid_drop: got %0b expected 0", m_valid); end
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL dc_back_to_idle: got %0b expected 1", cmd_ready); end
   endtask

   task automatic test_impulse();
      int pos[3];
      int want[3];
      bit ok;
      int exp;
      pos  = '{9, 0, 1};
      want = '{246, 79, -139};
      m_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 64; i++) pix_buf[i] = 0;
         pix_buf[pos[t]] = 1;
         exp_q.push_back(want[t]);
         send_cmd(5, 5, ok);
         send_pixels(0, 63, 0, ok);
         wait_mvalid(ok);
         exp = exp_q.pop_front();
         n_checks++;
         if (!ok || m_coef !== exp) begin
            n_fail++;
            $display("FAIL impulse_%0d: got %0d (valid %0b) expected %0d", pos[t], m_coef, m_valid, exp);
         end
         tick();
      end
   endtask

   task automatic test_random();
      bit ok;
      int k1;
      int k2;
      int exp;
      logic signed [31:0] held;
      for (int it = 0; it < 3; it++) begin
         k1 = int'($urandom_range(7));
         k2 = int'($urandom_range(7));
         for (int i = 0; i < 64; i++) pix_buf[i] = int'($urandom_range(511)) - 256;
         exp_q.push_back(model_coef(k1, k2));
         m_ready = 1'b0;
         send_cmd(k1, k2, ok);
         send_pixels(0, 63, 30, ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL random_%0d_pixels: got timeout expected all accepted", it); end
         n_checks++;
         if (s_ready !== 1'b0) begin n_fail++; $display("FAIL random_%0d_s_ready: got %0b expected 0", it, s_ready); end
         // Offer extra pixels after the block; they must not be taken.
         s_valid = 1'b1;
         s_data  = 9'sd77;
         wait_mvalid(ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL random_%0d_timeout: got m_valid 0 expected 1", it); end
         held = m_coef;
         for (int h = 0; h < 5; h++) begin
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_coef !== held) begin
               n_fail++;
               $display("FAIL random_%0d_hold_%0d: got %0d (valid %0b) expected %0d", it, h, m_coef, m_valid, held);
            end
         end
         exp = exp_q.pop_front();
         n_checks++;
         if (m_coef !== exp) begin n_fail++; $display("FAIL random_%0d_coef k=(%0d,%0d): got %0d expected %0d", it, k1, k2, m_coef, exp); end
         s_valid = 1'b0;
         m_ready = 1'b1;
         tick();
         m_ready = 1'b0;
         n_checks++;
         if (m_valid !== 1'b0) begin n_fail++; $display("FAIL random_%0d_m_valid_drop: got %0b expected 0", it, m_valid); end
      end
   endtask

   task automatic test_abort();
      bit ok;
      bit saw;
      int exp;
      m_ready = 1'b1;
      for (int i = 0; i < 64; i++) pix_buf[i] = int'($urandom_range(255));
      send_cmd(3, 4, ok);
      send_pixels(0, 20, 0, ok);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (m_valid) saw = 1'b1;
         tick();
      end
      n_checks++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_output: got m_valid seen expected none"); end
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_cmd_ready: got %0b expected 1", cmd_ready); end
      for (int i = 0; i < 64; i++) pix_buf[i] = 2;
      exp_q.push_back(32768);
      send_cmd(0, 0, ok);
      send_pixels(0, 63, 0, ok);
      wait_mvalid(ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || m_coef !== exp) begin n_fail++; $display("FAIL abort_restart_coef: got %0d (valid %0b) expected %0d", m_coef, m_valid, exp); end
      tick();
   endtask

   task automatic test_cmd_hold();
      bit ok;
      int budget;
      int n_out;
      int exp;
      for (int i = 0; i < 64; i++) pix_buf[i] = 1;
      exp_q.push_back(16384);
      m_ready   = 1'b0;
      cmd_valid = 1'b1;
      cmd_k1    = 3'd0;
      cmd_k2    = 3'd0;
      budget    = 200;
      while (!cmd_ready && budget > 0) begin tick(); budget--; end
      tick();
      // Keep requesting with a different k; it must not be taken mid-block.
      cmd_k1     = 3'd1;
      cmd_k2     = 3'd2;
      ready_seen = 1'b0;
      hold_mon   = 1'b1;
      send_pixels(0, 63, 20, ok);
      cmd_valid = 1'b1;
      wait_mvalid(ok);
      tick();
      tick();
      hold_mon = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL hold_cmd_ready: got 1 outside IDLE expected 0"); end
      n_checks++;
      if (!ok || m_coef !== exp) begin n_fail++; $display("FAIL hold_coef: got %0d (valid %0b) expected %0d", m_coef, m_valid, exp); end
      m_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle_after_done: got %0b expected 1", cmd_ready); end
      n_out = 0;
      for (int c = 0; c < 80; c++) begin
         if (m_valid) n_out++;
         tick();
      end
      n_checks++;
      if (n_out !== 0) begin n_fail++; $display("FAIL hold_extra_output: got %0d expected 0", n_out); end
   endtask

   task automatic test_sat();
      int budget;
      int exp;
`ifdef DCT_BASIS_ACCUM_SAT_EN
      exp_q.push_back(32767);
`else
      exp_q.push_back(-16384);
`endif
      sm_m_ready   = 1'b1;
      sm_cmd_valid = 1'b1;
      sm_cmd_k1    = 3'd0;
      sm_cmd_k2    = 3'd0;
      budget       = 200;
      while (!sm_cmd_ready && budget > 0) begin tick(); budget--; end
      tick();
      sm_cmd_valid = 1'b0;
      for (int i = 0; i < 64; i++) begin
         sm_s_valid = 1'b1;
         sm_s_data  = 8'sd127;
         budget     = 200;
         while (!sm_s_ready && budget > 0) begin tick(); budget--; end
         tick();
      end
      sm_s_valid = 1'b0;
      budget = 200;
      while (!sm_m_valid && budget > 0) begin tick(); budget--; end
      exp = exp_q.pop_front();
      n_checks++;
      if (!sm_m_valid || int'(sm_m_coef) !== exp) begin
         n_fail++;
         $display("FAIL small_coef: got %0d (valid %0b) expected %0d", sm_m_coef, sm_m_valid, exp);
      end
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      init_ctab();
      test_reset();
      test_dc();
      test_impulse();
      test_random();
      test_abort();
      test_cmd_hold();
      test_sat();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
